// File: rtl/aes_v1_arbiter.sv
// aes_v1_arbiter: shares one aes_v1 unit between two requesters (optional counters: AES_ARB_PERF_EN)
module aes_v1_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        req0_valid,
  input  logic        req0_dec,
  input  logic        req0_mix,
  input  logic [31:0] req0_rs1,
  output logic        req0_ready,
  output logic [31:0] req0_rd,
  input  logic        req1_valid,
  input  logic        req1_dec,
  input  logic        req1_mix,
  input  logic [31:0] req1_rs1,
  output logic        req1_ready,
  output logic [31:0] req1_rd,
  output logic        unit_valid,
  output logic        unit_dec,
  output logic        unit_mix,
  output logic [31:0] unit_rs1,
  input  logic        unit_ready,
  input  logic [31:0] unit_rd,
`ifdef AES_ARB_PERF_EN
  output logic [15:0] perf_grant0,
  output logic [15:0] perf_grant1,
  output logic [15:0] perf_stall,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state_q, state_d;
  logic        grant_q, grant_d, ptr_q, ptr_d, dec_q, dec_d, mix_q, mix_d;
  logic [31:0] rs1_q, rs1_d, res_q, res_d;
  logic        pick, any_req;
  assign any_req = req0_valid | req1_valid;
  assign pick    = (req0_valid & req1_valid) ? (RR_EN ? ptr_q : 1'b0) : req1_valid;
  // Next-state: latch the winner's operands in IDLE, wait for the unit in BUSY, hand over in RESP
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    dec_d   = dec_q;
    mix_d   = mix_q;
    rs1_d   = rs1_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = BUSY;
        grant_d = pick;
        dec_d   = pick ? req1_dec : req0_dec;
        mix_d   = pick ? req1_mix : req0_mix;
        rs1_d   = pick ? req1_rs1 : req0_rs1;
      end
      BUSY: if (unit_ready) begin
        state_d = RESP;
        res_d   = unit_rd;
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = ~grant_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and operand/result registers; reset clears everything so pointer favours requester 0
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      ptr_q   <= 1'b0;
      dec_q   <= 1'b0;
      mix_q   <= 1'b0;
      rs1_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      dec_q   <= dec_d;
      mix_q   <= mix_d;
      rs1_q   <= rs1_d;
      res_q   <= res_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign unit_valid = state_q == BUSY;
  assign unit_dec   = dec_q;
  assign unit_mix   = mix_q;
  assign unit_rs1   = rs1_q;
  assign req0_ready = (state_q == RESP) & ~grant_q;
  assign req1_ready = (state_q == RESP) & grant_q;
  assign req0_rd    = req0_ready ? res_q : 32'h0;
  assign req1_rd    = req1_ready ? res_q : 32'h0;
`ifdef AES_ARB_PERF_EN
  logic [15:0] grant0_q, grant0_d, grant1_q, grant1_d, stall_q, stall_d;
  logic        idle_grant;
  assign idle_grant = (state_q == IDLE) & any_req;
  // Saturating event counters: grants per requester and BUSY cycles spent waiting on the unit
  always_comb begin
    grant0_d = grant0_q + 16'((idle_grant & ~pick) & (grant0_q != 16'hFFFF));
    grant1_d = grant1_q + 16'((idle_grant & pick) & (grant1_q != 16'hFFFF));
    stall_d  = stall_q + 16'((state_q == BUSY) & ~unit_ready & (stall_q != 16'hFFFF));
  end
  // Counter registers
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      grant0_q <= '0;
      grant1_q <= '0;
      stall_q  <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      stall_q  <= stall_d;
    end
  end
  assign perf_grant0 = grant0_q;
  assign perf_grant1 = grant1_q;
  assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_aes_v1_arbiter.sv
// tb_aes_v1_arbiter: directed scoreboard bench with a stub AES unit and a fixed-priority second instance
module tb_aes_v1_arbiter;
  logic        g_clk, g_reset;
  logic        req0_valid, req0_dec, req0_mix, req1_valid, req1_dec, req1_mix;
  logic [31:0] req0_rs1, req1_rs1, req0_rd, req1_rd, unit_rs1, unit_rd;
  logic        req0_ready, req1_ready, unit_valid, unit_dec, unit_mix, unit_ready, busy;
  logic        b_r0, b_r1, b_uv, b_ud, b_um, b_busy;
  logic [31:0] b_rd0, b_rd1, b_urs1;
`ifdef AES_ARB_PERF_EN
  logic [15:0] perf_grant0, perf_grant1, perf_stall, b_pg0, b_pg1, b_ps;
`endif
  int total = 0, bad = 0, stall_n = 0, wait_cnt = 0, b0_cnt = 0, b1_cnt = 0;
  logic [32:0] sb[$];

  aes_v1_arbiter dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .req0_valid(req0_valid), .req0_dec(req0_dec), .req0_mix(req0_mix), .req0_rs1(req0_rs1),
    .req0_ready(req0_ready), .req0_rd(req0_rd),
    .req1_valid(req1_valid), .req1_dec(req1_dec), .req1_mix(req1_mix), .req1_rs1(req1_rs1),
    .req1_ready(req1_ready), .req1_rd(req1_rd),
    .unit_valid(unit_valid), .unit_dec(unit_dec), .unit_mix(unit_mix), .unit_rs1(unit_rs1),
    .unit_ready(unit_ready), .unit_rd(unit_rd),
`ifdef AES_ARB_PERF_EN
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  aes_v1_arbiter #(.RR_EN(1'b0)) fixed (
    .g_clk(g_clk), .g_reset(g_reset),
    .req0_valid(req0_valid), .req0_dec(req0_dec), .req0_mix(req0_mix), .req0_rs1(req0_rs1),
    .req0_ready(b_r0), .req0_rd(b_rd0),
    .req1_valid(req1_valid), .req1_dec(req1_dec), .req1_mix(req1_mix), .req1_rs1(req1_rs1),
    .req1_ready(b_r1), .req1_rd(b_rd1),
    .unit_valid(b_uv), .unit_dec(b_ud), .unit_mix(b_um), .unit_rs1(b_urs1),
    .unit_ready(b_uv), .unit_rd(b_urs1),
`ifdef AES_ARB_PERF_EN
    .perf_grant0(b_pg0), .perf_grant1(b_pg1), .perf_stall(b_ps),
`endif
    .busy(b_busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Stub AES unit: a few real aes_v1 vectors, otherwise a cheap distinct transform
  function automatic logic [31:0] unit_fn(logic [31:0] a, logic d, logic m);
    if (!d && !m && a == 32'h0) return 32'h63636363;
    if (d && !m && a == 32'h63636363) return 32'h0;
    if (!d && m && a == 32'h455313db) return 32'hbca14d8e;
    return {a[23:0], a[31:24]} ^ {29'h0, d, m, 1'b1};
  endfunction

  assign unit_ready = unit_valid && (wait_cnt >= stall_n);
  assign unit_rd    = unit_fn(unit_rs1, unit_dec, unit_mix);
  always @(posedge g_clk) wait_cnt <= (unit_valid && !unit_ready) ? wait_cnt + 1 : 0;

  always @(negedge g_clk) begin
    if (b_r0) b0_cnt <= b0_cnt + 1;
    if (b_r1) b1_cnt <= b1_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest pending expectation
  always @(negedge g_clk) begin
    logic [32:0] e;
    if (!g_reset) begin
      chk("both_ready", 32'(req0_ready & req1_ready), 32'h0);
      chk("rd0_quiet", req0_ready ? 32'h0 : req0_rd, 32'h0);
      chk("rd1_quiet", req1_ready ? 32'h0 : req1_rd, 32'h0);
      if (req0_ready || req1_ready) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL sb_underflow observed=ready0:%b ready1:%b expected=no ready", req0_ready, req1_ready);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("ready_id", 32'(req1_ready), 32'(e[32]));
          chk("result", req1_ready ? req1_rd : req0_rd, e[31:0]);
        end
      end
    end
  end

  task automatic run_op(input bit id, input bit d, input bit m, input logic [31:0] a,
                        input logic [31:0] exp, input int exp_lat, input bit chg, input logic [31:0] a2);
    int lat;
    bit done;
    lat = 0;
    done = 1'b0;
    @(negedge g_clk);
    sb.push_back({id, exp});
    if (id) begin req1_valid = 1; req1_dec = d; req1_mix = m; req1_rs1 = a; end
    else begin req0_valid = 1; req0_dec = d; req0_mix = m; req0_rs1 = a; end
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge g_clk);
      if (chg && i == 1) begin
        if (id) req1_rs1 = a2; else req0_rs1 = a2;
      end
      if (id ? req1_ready : req0_ready) begin
        done = 1'b1;
        lat = i;
      end else begin
        chk("busy_wait", 32'(busy), 32'h1);
        chk("unit_valid_wait", 32'(unit_valid), 32'h1);
        chk("unit_rs1_stable", unit_rs1, a);
        chk("unit_op_stable", 32'({unit_dec, unit_mix}), 32'({d, m}));
      end
    end
    if (id) req1_valid = 0; else req0_valid = 0;
    chk("ready_seen", 32'(done), 32'h1);
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int s0, s1;
    g_reset = 1;
    {req0_valid, req0_dec, req0_mix, req1_valid, req1_dec, req1_mix} = '0;
    req0_rs1 = 0;
    req1_rs1 = 0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_unit_valid", 32'(unit_valid), 32'h0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'h0);
    chk("rst_unit_rs1", unit_rs1, 32'h0);
    repeat (2) @(negedge g_clk);
    g_reset = 0;
    run_op(0, 0, 0, 32'h00000000, 32'h63636363, 2, 0, 0);
    run_op(1, 1, 0, 32'h63636363, 32'h00000000, 2, 0, 0);
    run_op(1, 0, 1, 32'h455313db, 32'hbca14d8e, 2, 0, 0);
    run_op(0, 0, 0, 32'h12345678, unit_fn(32'h12345678, 0, 0), 2, 1, 32'hdeadbeef);
    stall_n = 5;
    run_op(0, 1, 1, 32'hcafef00d, unit_fn(32'hcafef00d, 1, 1), 7, 0, 0);
    stall_n = 0;
`ifdef AES_ARB_PERF_EN
    chk("perf_stall", 32'(perf_stall), 32'd5);
    chk("perf_grant0", 32'(perf_grant0), 32'd3);
    chk("perf_grant1", 32'(perf_grant1), 32'd2);
`endif
    // Abort an operation in BUSY with reset; no ready may follow
    @(negedge g_clk);
    req1_valid = 1;
    req1_rs1 = 32'h55aa55aa;
    stall_n = 3;
    @(negedge g_clk);
    chk("abort_busy_before", 32'(busy), 32'h1);
    #1 g_reset = 1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_unit_valid", 32'(unit_valid), 32'h0);
    chk("abort_ready", 32'({req0_ready, req1_ready}), 32'h0);
    @(negedge g_clk);
    req1_valid = 0;
    g_reset = 0;
    stall_n = 0;
`ifdef AES_ARB_PERF_EN
    chk("perf_rst", 32'({perf_grant0, perf_stall}), 32'h0);
`endif
    repeat (4) @(negedge g_clk);
    chk("abort_no_pending", 32'(sb.size()), 32'h0);
    run_op(1, 0, 0, 32'h0badf00d, unit_fn(32'h0badf00d, 0, 0), 2, 0, 0);
    // Both requesters held valid: round robin alternates, fixed priority serves only req0
    @(negedge g_clk);
    g_reset = 1;
    @(negedge g_clk);
    g_reset = 0;
    s0 = b0_cnt;
    s1 = b1_cnt;
    for (int k = 0; k < 4; k++)
      sb.push_back((k % 2) ? {1'b1, unit_fn(32'h22222222, 1, 0)} : {1'b0, unit_fn(32'h11111111, 0, 1)});
    req0_dec = 0; req0_mix = 1; req0_rs1 = 32'h11111111;
    req1_dec = 1; req1_mix = 0; req1_rs1 = 32'h22222222;
    req0_valid = 1;
    req1_valid = 1;
    repeat (11) @(negedge g_clk);
    req0_valid = 0;
    req1_valid = 0;
    repeat (3) @(negedge g_clk);
    chk("rr_all_served", 32'(sb.size()), 32'h0);
    chk("fixed_req0_count", 32'(b0_cnt - s0), 32'd4);
    chk("fixed_req1_count", 32'(b1_cnt - s1), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
